trace_filter_prog: RTL
======================

# trace_filter_prog

Parametrised, registered successor of the trace instruction filter. Classifies each traced instruction (PC + instruction word) as kept or dropped using fixed control-flow decode (branch/jump/return/WFI, 32-bit and compressed) and/or a small table of programmable mask/value rules. Kept items are forwarded through a one-stage valid/ready output register to the trace FIFO. Optional saturating kept/dropped counters.

## Interface
- `PC_WIDTH`, 64, width of the PC field carried with each instruction.
- `NUM_RULES`, 4, number of programmable mask/value rules (1..16).
- `CNT_WIDTH`, 32, width of each statistics counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input item valid.
- `in_ready`  out  1  input can be accepted this cycle.
- `in_pc`  in  PC_WIDTH  PC of instruction.
- `in_instr`  in  32  instruction word (compressed in [15:0]).
- `mode`  in  2  00 pass all, 01 fixed decode only, 10 rules only, 11 fixed OR rules.
- `cfg_we`  in  1  write rule `cfg_idx`.
- `cfg_idx`  in  $clog2(NUM_RULES) (min 1)  rule index.
- `cfg_en`, `cfg_mask`, `cfg_value`  in  1 / 32 / 32  rule enable, mask, match value.
- `out_valid`  out  1  kept item valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`, `out_instr`  out  PC_WIDTH / 32  kept item.
- `stats_clr`  in  1  clear counters.
- `kept_cnt`, `drop_cnt`  out  CNT_WIDTH each  statistics.

## Operation
- Accept: `acc = in_valid & in_ready`; `in_ready = ~out_valid | out_ready` (combinational).
- Fixed decode (`fix`) true for any of: instr[6:0] ∈ {1100011, 1101111, 1100111}; instr == 32'h10500073 (WFI); instr[1:0]=01 and instr[15:13] ∈ {001, 101, 110, 111} (C.JAL, C.J, C.BEQZ, C.BNEZ); instr[1:0]=10, instr[15:13]=100, instr[11:7]≠0, instr[6:2]=0 (C.JR/C.JALR).
- Rule i hits when `en_i & ((instr & mask_i) == value_i)`; `rul` = OR of hits.
- keep = mode 00: 1; 01: fix; 10: rul; 11: fix|rul.
- On `acc & keep`: output register loads in_pc/in_instr, out_valid←1.
- On `acc & ~keep`: item consumed; if `out_valid & out_ready` then out_valid←0, else output unchanged.
- No acc and `out_valid & out_ready`: out_valid←0.
- out_pc/out_instr hold value while out_valid=1 and out_ready=0.
- Rule write: on `cfg_we`, entry `cfg_idx` ← {cfg_en, cfg_mask, cfg_value}; cfg_idx ≥ NUM_RULES ignored.
- Counters: kept_cnt +1 on `acc & keep`, drop_cnt +1 on `acc & ~keep`; both saturate at all-ones.

## Timing
- Latency 1 cycle: item accepted at edge N visible on out_* after edge N; full throughput (1/cycle) when out_ready=1.
- Simultaneous accept-keep and output handshake: new item replaces old, out_valid stays 1.
- Rule write and acc same cycle: classification uses old rule contents; new contents apply from next cycle.
- mode sampled combinationally in the accept cycle.
- stats_clr with increment same cycle: clear wins (counter = 0).
- Reset values: out_valid 0, out_pc 0, out_instr 0, all rules en=0/mask=0/value=0, kept_cnt 0, drop_cnt 0. in_ready=1 after reset. Reset mid-operation discards the pending output item.

## Configuration
- `TRACE_FILTER_STATS_EN`: defined → counters and stats_clr logic implemented as above. Undefined → no counter registers; kept_cnt and drop_cnt tied to 0; stats_clr ignored. Filtering behaviour identical either way.

## Test plan
- Reset, mode=01, out_ready=1, stream 32'h00000063 (BEQ), 32'h00000013 (ADDI), 32'h0000006F (JAL), 16'hA001 (C.J) → out sequence 0x63, 0x6F, 0xA001, each 1 cycle after accept; kept_cnt=3, drop_cnt=1.
- mode=01: 32'h10500073 kept; 16'h8082 (C.JR ra) kept; 16'h8006 (C.MV) dropped; 32'h00000067 (JALR) kept.
- mode=10, rule0 {en=1, mask=32'h0000707F, value=32'h00003003} (LD): 32'h0000B083 kept, 32'h00000063 dropped; rule write in same cycle as accept → old rule used for that item.
- Backpressure: mode=00, out_ready=0, two items → first held stable, in_ready=0, second not accepted until out_ready=1; no loss, no duplication.
- Saturation/clear (STATS_EN defined, CNT_WIDTH=4): 20 kept items → kept_cnt=15; stats_clr asserted with a keep → kept_cnt=0; without macro counters read 0.
- Assert rst while out_valid=1 → out_valid=0 immediately (async), rules cleared, counters 0.

Source files
------------

// File: rtl/trace_filter_prog.sv
// Trace instruction filter: fixed control-flow decode plus programmable mask/value rules,
// one-stage valid/ready output register. Optional counters under `TRACE_FILTER_STATS_EN.
module trace_filter_prog #(
    parameter int PC_WIDTH  = 64,
    parameter int NUM_RULES = 4,
    parameter int CNT_WIDTH = 32,
    localparam int IDX_W    = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [31:0]          in_instr,
    input  logic [1:0]           mode,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic                 cfg_en,
    input  logic [31:0]          cfg_mask,
    input  logic [31:0]          cfg_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [31:0]          out_instr,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] kept_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    logic                r_rule_en    [NUM_RULES];
    logic [31:0]         r_rule_mask  [NUM_RULES];
    logic [31:0]         r_rule_value [NUM_RULES];
    logic                r_out_valid;
    logic [PC_WIDTH-1:0] r_out_pc;
    logic [31:0]         r_out_instr;

    logic w_acc;
    logic w_fix;
    logic w_rul;
    logic w_keep;

    function automatic logic f_fix(input logic [31:0] ins);
        logic w_op32;
        logic w_wfi;
        logic w_cq1;
        logic w_cjr;
        w_op32 = (ins[6:0] == 7'b1100011) || (ins[6:0] == 7'b1101111) ||
                 (ins[6:0] == 7'b1100111);
        w_wfi  = (ins == 32'h1050_0073);
        w_cq1  = (ins[1:0] == 2'b01) &&
                 ((ins[15:13] == 3'b001) || (ins[15:13] == 3'b101) ||
                  (ins[15:13] == 3'b110) || (ins[15:13] == 3'b111));
        w_cjr  = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100) &&
                 (ins[11:7] != 5'd0) && (ins[6:2] == 5'd0);
        return w_op32 | w_wfi | w_cq1 | w_cjr;
    endfunction

    assign in_ready = ~r_out_valid | out_ready;
    assign w_acc    = in_valid & in_ready;
    assign w_fix    = f_fix(in_instr);

    always_comb begin
        w_rul = 1'b0;
        for (int unsigned i = 0; i < NUM_RULES; i++) begin
            if (r_rule_en[i] && ((in_instr & r_rule_mask[i]) == r_rule_value[i])) begin
                w_rul = 1'b1;
            end
        end
    end

    always_comb begin
        w_keep = 1'b1;
        case (mode)
            2'b00:   w_keep = 1'b1;
            2'b01:   w_keep = w_fix;
            2'b10:   w_keep = w_rul;
            default: w_keep = w_fix | w_rul;
        endcase
    end

    // Rule writes land after the edge, so an item accepted in the same cycle sees old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_RULES; i++) begin
                r_rule_en[i]    <= 1'b0;
                r_rule_mask[i]  <= '0;
                r_rule_value[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_RULES; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    r_rule_en[i]    <= cfg_en;
                    r_rule_mask[i]  <= cfg_mask;
                    r_rule_value[i] <= cfg_value;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
        end else if (w_acc && w_keep) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= in_pc;
            r_out_instr <= in_instr;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_instr = r_out_instr;

`ifdef TRACE_FILTER_STATS_EN
    logic [CNT_WIDTH-1:0] r_kept_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kept_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (stats_clr) begin
            r_kept_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_acc && w_keep && (r_kept_cnt != '1)) begin
                r_kept_cnt <= r_kept_cnt + 1'b1;
            end
            if (w_acc && !w_keep && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign kept_cnt = r_kept_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
    assign kept_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule
